// File: rtl/interleave_merge.sv
// Round-robin merge of NUM_LANES lane FIFOs into one registered valid/ready stream.
// Optional INTERLEAVE_MERGE_SKID_EN adds a skid entry and registers in_ready.
module interleave_merge #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES = 2,
  localparam int LB_LANES = $clog2(NUM_LANES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_LANES-1:0]            in_valid,
  output logic [NUM_LANES-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LB_LANES-1:0]             lane_sel
);

  logic [LB_LANES-1:0]   sel_q, sel_d;
  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [DATA_WIDTH-1:0] lane_word;
  logic                  lane_vld;
  logic                  load;
  logic                  gate;
  logic                  take;

`ifdef INTERLEAVE_MERGE_SKID_EN
  logic                  skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH-1:0] skid_dat_q, skid_dat_d;
`endif

  always_comb begin
    lane_word = '0;
    lane_vld  = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (sel_q == LB_LANES'(k)) begin
        lane_word = in_data[k*DATA_WIDTH +: DATA_WIDTH];
        lane_vld  = in_valid[k];
      end
    end
  end

  assign load = !vld_q || out_ready;

`ifdef INTERLEAVE_MERGE_SKID_EN
  // Skid empty is enough to accept, so out_ready never reaches in_ready.
  assign gate = !skid_vld_q && !clear && !rst;
`else
  assign gate = load && !clear && !rst;
`endif

  assign take = gate && lane_vld;

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      in_ready[k] = gate && (sel_q == LB_LANES'(k));
    end
  end

  always_comb begin
    sel_d = sel_q;
    vld_d = vld_q;
    dat_d = dat_q;
`ifdef INTERLEAVE_MERGE_SKID_EN
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
`endif
    if (take) begin
      if (sel_q == LB_LANES'(NUM_LANES - 1)) sel_d = '0;
      else sel_d = sel_q + 1'b1;
    end
`ifdef INTERLEAVE_MERGE_SKID_EN
    if (load) begin
      if (skid_vld_q) begin
        vld_d      = 1'b1;
        dat_d      = skid_dat_q;
        skid_vld_d = 1'b0;
      end else begin
        vld_d = take;
        if (take) dat_d = lane_word;
      end
    end else if (take) begin
      skid_vld_d = 1'b1;
      skid_dat_d = lane_word;
    end
`else
    if (load) begin
      vld_d = take;
      if (take) dat_d = lane_word;
    end
`endif
    if (clear) begin
      sel_d = '0;
      vld_d = 1'b0;
`ifdef INTERLEAVE_MERGE_SKID_EN
      skid_vld_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= '0;
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      sel_q <= sel_d;
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

`ifdef INTERLEAVE_MERGE_SKID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
    end else begin
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end
`endif

  assign out_data  = dat_q;
  assign out_valid = vld_q;
  assign lane_sel  = sel_q;

endmodule

// File: tb/tb_interleave_merge.sv
// Scoreboard bench for interleave_merge: 2-lane and 3-lane instances
// fed by behavioural lane FIFOs; expected order is the dispatch order.
module tb_interleave_merge;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic out_ready;

  logic [15:0] in_data2;
  logic [1:0]  in_valid2;
  logic [1:0]  in_ready2;
  logic [7:0]  out_data2;
  logic        out_valid2;
  logic [0:0]  lane_sel2;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic [1:0]  lane_sel3;

  always #5 clk = ~clk;

  interleave_merge #(.DATA_WIDTH(8), .NUM_LANES(2)) u_m2 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .lane_sel(lane_sel2)
  );

  interleave_merge #(.DATA_WIDTH(8), .NUM_LANES(3)) u_m3 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready),
    .lane_sel(lane_sel3)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] lq0[$];
  logic [7:0] lq1[$];
  logic [7:0] lq2[$];
  logic [7:0] exp_q[$];
  logic [2:0] en;
  logic [2:0] vdrv;
  int nl;
  int dptr;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] rdy();
    return (nl == 2) ? {1'b0, in_ready2} : in_ready3;
  endfunction

  function automatic logic ovf();
    return (nl == 2) ? out_valid2 : out_valid3;
  endfunction

  function automatic logic [7:0] odf();
    return (nl == 2) ? out_data2 : out_data3;
  endfunction

  function automatic logic [1:0] lsf();
    return (nl == 2) ? {1'b0, lane_sel2} : lane_sel3;
  endfunction

  function automatic void dispatch(input logic [7:0] w);
    case (dptr)
      0: lq0.push_back(w);
      1: lq1.push_back(w);
      default: lq2.push_back(w);
    endcase
    exp_q.push_back(w);
    dptr = (dptr + 1) % nl;
  endfunction

  function automatic void drive();
    logic [2:0]  v;
    logic [23:0] d;
    v = '0;
    d = '0;
    if (lq0.size() > 0) begin v[0] = en[0]; d[7:0]   = lq0[0]; end
    if (lq1.size() > 0) begin v[1] = en[1]; d[15:8]  = lq1[0]; end
    if (lq2.size() > 0) begin v[2] = en[2]; d[23:16] = lq2[0]; end
    if (nl == 2) begin
      v[2] = 1'b0;
      in_valid2 = v[1:0];
      in_data2  = d[15:0];
      in_valid3 = '0;
      in_data3  = '0;
    end else begin
      in_valid2 = '0;
      in_data2  = '0;
      in_valid3 = v;
      in_data3  = d;
    end
    vdrv = v;
  endfunction

  // Entered at a negedge; leaves at the following negedge.
  task automatic cyc();
    logic [2:0] hs;
    drive();
    #4;
    hs = vdrv & rdy();
    if (ovf() && out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 32'(odf()), 32'hFFFF);
      else chk("sb_word", 32'(odf()), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    if (hs[0]) void'(lq0.pop_front());
    if (hs[1]) void'(lq1.pop_front());
    if (hs[2]) void'(lq2.pop_front());
    if (clear) begin
      lq0.delete();
      lq1.delete();
      lq2.delete();
      exp_q.delete();
      dptr = 0;
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) cyc();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  logic [7:0] held;

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    out_ready = 1'b1;
    nl = 2;
    dptr = 0;
    en = 3'b111;
    drive();
    repeat (10) @(negedge clk);
    chk("rst_ov2", 32'(out_valid2), 0);
    chk("rst_ls2", 32'(lane_sel2), 0);
    chk("rst_rdy2", 32'(in_ready2), 0);
    chk("rst_od2", 32'(out_data2), 0);
    chk("rst_rdy3", 32'(in_ready3), 0);
    chk("rst_ls3", 32'(lane_sel3), 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_ov", 32'(ovf()), 0);
    chk("post_rst_ls", 32'(lsf()), 0);

    // round-robin order
    dispatch(8'h10);
    dispatch(8'h11);
    dispatch(8'h12);
    dispatch(8'h13);
    for (int i = 0; i < 4; i++) begin
      chk("ord_ls", 32'(lsf()), 32'(i % 2));
      cyc();
      chk("ord_ov", 32'(ovf()), 1);
    end
    drain("ord_drain");
    chk("ord_idle", 32'(ovf()), 0);

    // head-of-line blocking
    en = 3'b010;
    dispatch(8'h20);
    dispatch(8'h21);
    repeat (3) cyc();
    held = {5'd0, rdy()};
    chk("blk_rdy1", 32'(held[1]), 0);
    chk("blk_ov", 32'(ovf()), 0);
    chk("blk_l1", 32'(lq1.size()), 1);
    en = 3'b111;
    cyc();
    chk("blk_ov1", 32'(ovf()), 1);
    chk("blk_od", 32'(odf()), 32'h20);
    drain("blk_drain");

    // backpressure
    for (int i = 0; i < 8; i++) dispatch(8'(8'h30 + i));
    cyc();
    cyc();
    out_ready = 1'b0;
    held = odf();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_od", 32'(odf()), 32'(held));
      chk("bp_ov", 32'(ovf()), 1);
`ifndef INTERLEAVE_MERGE_SKID_EN
      chk("bp_rdy", 32'(rdy()), 0);
`endif
    end
    out_ready = 1'b1;
    drain("bp_drain");
    chk("bp_lanes", 32'(lq0.size() + lq1.size()), 0);

    // three lanes, lane_sel wrap
    nl = 3;
    dptr = 0;
    for (int i = 0; i < 9; i++) dispatch(8'(i));
    for (int i = 0; i < 9; i++) begin
      chk("wrap_ls", 32'(lsf()), 32'(i % 3));
      cyc();
    end
    drain("wrap_drain");
    chk("wrap_ls_end", 32'(lsf()), 0);

    // clear mid-stream
    nl = 2;
    dptr = 0;
    for (int i = 0; i < 8; i++) dispatch(8'(8'h40 + i));
    repeat (3) cyc();
    out_ready = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_ov", 32'(ovf()), 0);
    chk("clr_ls", 32'(lsf()), 0);
    dispatch(8'hA0);
    out_ready = 1'b1;
    cyc();
    chk("clr_ov1", 32'(ovf()), 1);
    chk("clr_od", 32'(odf()), 32'hA0);
    drain("clr_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
